// File: rtl/vault_work_dispatcher_pkg.sv
// Shared types and widths for the vault work dispatcher: package width, loader
// states and the {job_id, nonce} result record.
package vault_pkg;
    localparam int VAULT_WORK_W   = 640;
    localparam int VAULT_NONCE_W  = 32;
    localparam int VAULT_JOB_ID_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_COMMIT = 2'd2
    } loader_state_e;

    typedef struct packed {
        logic [VAULT_JOB_ID_W-1:0] job_id;
        logic [VAULT_NONCE_W-1:0]  nonce;
    } vault_result_t;
endpackage

// File: rtl/vault_work_dispatcher_if.sv
// Host word stream, core-facing package/nonce and result drain signals.
// slave = dispatcher side, master = host/core side.
interface vault_work_dispatcher_if
    import vault_pkg::*;
#(
    parameter int WORDS    = 20,
    parameter int JOB_ID_W = 8
);
    logic [VAULT_NONCE_W-1:0]          s_word_data;
    logic                              s_word_valid;
    logic                              s_word_ready;
    logic                              s_word_last;
    logic [JOB_ID_W-1:0]               s_job_id;
    logic [WORDS*VAULT_NONCE_W-1:0]    work_package;
    logic                              work_load;
    logic [JOB_ID_W-1:0]               active_job_id;
    logic [VAULT_NONCE_W-1:0]          golden_nonce;
    logic [JOB_ID_W+VAULT_NONCE_W-1:0] m_result_data;
    logic                              m_result_valid;
    logic                              m_result_ready;
    logic [7:0]                        drop_count;
    logic                              frame_err;

    modport slave (
        input  s_word_data, s_word_valid, s_word_last, s_job_id, golden_nonce, m_result_ready,
        output s_word_ready, work_package, work_load, active_job_id,
               m_result_data, m_result_valid, drop_count, frame_err
    );

    modport master (
        output s_word_data, s_word_valid, s_word_last, s_job_id, golden_nonce, m_result_ready,
        input  s_word_ready, work_package, work_load, active_job_id,
               m_result_data, m_result_valid, drop_count, frame_err
    );
endinterface

// File: rtl/vault_work_dispatcher_result_fifo.sv
// First-word-fall-through result FIFO; callers gate wr_en_i with !full_o and
// rd_en_i with !empty_o.
module vault_result_fifo #(
    parameter int DATA_W = 40,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]    wr_ptr_q;
    logic [PTR_W:0]    rd_ptr_q;

    // Extra MSB on each pointer separates full from empty when the indices match.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign rd_data_o = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data_i;
    end
endmodule

// File: rtl/vault_work_dispatcher.sv
// Assembles host words into a shadow work package, commits it to the mining core,
// and tags new golden nonces with the active job into a result FIFO.
module vault_work_dispatcher
    import vault_pkg::*;
#(
    parameter int WORDS      = 20,
    parameter int FIFO_DEPTH = 4,
    parameter int JOB_ID_W   = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    vault_work_dispatcher_if.slave bus
);
    localparam int PKG_W = WORDS * VAULT_NONCE_W;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    loader_state_e             state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      frame_err_q, frame_err_d;
    logic [VAULT_NONCE_W-1:0]  shadow_q [WORDS];
    logic [PKG_W-1:0]          shadow_flat;
    logic [JOB_ID_W-1:0]       shadow_tag_q;
    logic [PKG_W-1:0]          work_package_q;
    logic [JOB_ID_W-1:0]       active_job_q;
    logic                      work_load_q;
    logic                      job_active_q;
    logic [VAULT_NONCE_W-1:0]  nonce_q;
    logic [VAULT_NONCE_W-1:0]  last_nonce_q;
    logic [7:0]                drop_count_q;
    logic                      commit;
    logic                      word_acc;
    logic                      push_req;
    logic                      fifo_full;
    logic                      fifo_empty;

    assign commit   = (state_q == ST_COMMIT);
    assign word_acc = bus.s_word_valid && !commit;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frame_err_d = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_FILL: begin
                if (word_acc) begin
                    // last must be set on the final word and only there
                    if (bus.s_word_last != (idx_q == LAST_IDX)) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                        idx_d       = '0;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ST_COMMIT;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_FILL;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            frame_err_q  <= 1'b0;
            shadow_tag_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_err_q <= frame_err_d;
            if (word_acc && state_q == ST_IDLE) shadow_tag_q <= bus.s_job_id;
        end
    end

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_shadow
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                                 shadow_q[gi] <= '0;
            else if (word_acc && idx_q == IDX_W'(gi))   shadow_q[gi] <= bus.s_word_data;
        end
        // word 0 lands in the most significant slot
        assign shadow_flat[PKG_W-1-VAULT_NONCE_W*gi -: VAULT_NONCE_W] = shadow_q[gi];
    end

    assign push_req = (nonce_q != '0) && (nonce_q != last_nonce_q) && job_active_q && !commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_package_q <= '0;
            active_job_q   <= '0;
            work_load_q    <= 1'b0;
            job_active_q   <= 1'b0;
            nonce_q        <= '0;
            last_nonce_q   <= '0;
            drop_count_q   <= '0;
        end else begin
            work_load_q <= commit;
            nonce_q     <= bus.golden_nonce;
            if (commit) begin
                work_package_q <= shadow_flat;
                active_job_q   <= shadow_tag_q;
                job_active_q   <= 1'b1;
                last_nonce_q   <= '0;
            end else if (push_req) begin
                last_nonce_q <= nonce_q;
            end
            if (push_req && fifo_full && drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 1'b1;
        end
    end

    vault_result_fifo #(
        .DATA_W (JOB_ID_W + VAULT_NONCE_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (push_req && !fifo_full),
        .wr_data_i ({active_job_q, nonce_q}),
        .rd_en_i   (!fifo_empty && bus.m_result_ready),
        .rd_data_o (bus.m_result_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign bus.s_word_ready   = !commit;
    assign bus.work_package   = work_package_q;
    assign bus.work_load      = work_load_q;
    assign bus.active_job_id  = active_job_q;
    assign bus.m_result_valid = !fifo_empty;
    assign bus.drop_count     = drop_count_q;
    assign bus.frame_err      = frame_err_q;
endmodule
